// File: rtl/axis_serdes_pkg.sv
// Shared definitions for the mesh-endpoint AXI-Stream serializer/deserializer pair.
// Holds the slice/counter width helpers and the wide-beat record used on the user side.
package axis_serdes_pkg;

   // Default geometry of the user-side beat
   localparam int DEF_TDATA_WIDTH = 512;
   localparam int DEF_TDEST_WIDTH = 4;
   localparam int DEF_SER_FACTOR  = 4;

   // Width of one NoC-side slice
   function automatic int slice_width(input int tdata_width, input int ser_factor);
      return tdata_width / ser_factor;
   endfunction

   // Width of the slice counter; never narrower than one bit
   function automatic int cnt_width(input int ser_factor);
      return (ser_factor > 1) ? $clog2(ser_factor) : 1;
   endfunction

   // One reassembled beat at the default geometry
   typedef struct packed {
      logic [DEF_TDATA_WIDTH-1:0] tdata;
      logic                       tlast;
      logic [DEF_TDEST_WIDTH-1:0] tdest;
   } axis_beat_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-entry valid/ready register stage. Accepts a new word whenever it is empty
// or its current word is being drained in the same cycle, so a full stage can be
// refilled without a bubble. Outputs come straight from flops.
module axis_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic load;

   assign in_ready = ~out_valid | out_ready;
   assign load     = in_valid & in_ready;

   // Load has priority over drain so a simultaneous drain+load keeps out_valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_deserializer.sv
// Reassembles one wide AXI-Stream beat from SERIALIZATION_FACTOR narrow slices (LSB first).
// Slices 0..SF-2 are parked in an accumulation register; the final slice and the
// accumulator are written together into an output register stage (axis_pipe_reg).
// Optional protocol checker: define AXIS_DESER_CHECK_EN to enable the sticky err flag
// (tdest change within a beat, or tlast on a non-final slice). Otherwise err is 0.
module axis_deserializer
   import axis_serdes_pkg::*;
#(
   parameter int TDATA_WIDTH          = 512,
   parameter int TDEST_WIDTH          = 4,
   parameter int SERIALIZATION_FACTOR = 4
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         s_tvalid,
   output logic                                         s_tready,
   input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]  s_tdata,
   input  logic                                         s_tlast,
   input  logic [TDEST_WIDTH-1:0]                       s_tdest,
   output logic                                         m_tvalid,
   input  logic                                         m_tready,
   output logic [TDATA_WIDTH-1:0]                       m_tdata,
   output logic                                         m_tlast,
   output logic [TDEST_WIDTH-1:0]                       m_tdest,
   output logic                                         err
);

   localparam int SW     = slice_width(TDATA_WIDTH, SERIALIZATION_FACTOR);
   localparam int CW     = cnt_width(SERIALIZATION_FACTOR);
   localparam int ACC_W  = TDATA_WIDTH - SW;
   localparam int BEAT_W = TDATA_WIDTH + 1 + TDEST_WIDTH;
   localparam logic [CW-1:0] LAST_CNT = CW'(SERIALIZATION_FACTOR - 1);

   logic [CW-1:0]                   cnt;
   logic [ACC_W-1:0]                acc;
   logic [SERIALIZATION_FACTOR-2:0] slice_en;
   logic                            is_final;
   logic                            s_fire;
   logic                            pipe_ready;
   logic                            pipe_load_valid;
   logic [BEAT_W-1:0]               load_beat;
   logic [BEAT_W-1:0]               out_beat;

   // Only the final slice can be blocked: it needs room in the output stage
   assign is_final        = (cnt == LAST_CNT);
   assign s_tready        = ~is_final | pipe_ready;
   assign s_fire          = s_tvalid & s_tready;
   assign pipe_load_valid = s_tvalid & is_final;

   // One write strobe per accumulator lane, selected by the slice counter
   for (genvar gi = 0; gi < SERIALIZATION_FACTOR - 1; gi++) begin : g_slice_en
      assign slice_en[gi] = s_fire & (cnt == CW'(gi));
   end

   // Park non-final slices in their lane of the accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else begin
         for (int k = 0; k < SERIALIZATION_FACTOR - 1; k++) begin
            if (slice_en[k]) begin
               acc[k*SW +: SW] <= s_tdata;
            end
         end
      end
   end

   // Slice counter: advance per accepted slice, wrap after the final one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (s_fire) begin
         cnt <= is_final ? '0 : cnt + CW'(1);
      end
   end

   // Final slice lands on top of the accumulated lanes; tlast/tdest come from it
   assign load_beat = {s_tdata, acc, s_tlast, s_tdest};

   axis_pipe_reg #(
      .WIDTH (BEAT_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (pipe_load_valid),
      .in_ready  (pipe_ready),
      .in_data   (load_beat),
      .out_valid (m_tvalid),
      .out_ready (m_tready),
      .out_data  (out_beat)
   );

   assign m_tdata = out_beat[BEAT_W-1 -: TDATA_WIDTH];
   assign m_tlast = out_beat[TDEST_WIDTH];
   assign m_tdest = out_beat[TDEST_WIDTH-1:0];

`ifdef AXIS_DESER_CHECK_EN
   logic [TDEST_WIDTH-1:0] dest0;
   logic                   err_flag;

   // Remember slice 0's tdest and latch any in-beat protocol violation until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest0    <= '0;
         err_flag <= 1'b0;
      end else if (s_fire) begin
         if (cnt == '0) begin
            dest0 <= s_tdest;
         end else if (s_tdest != dest0) begin
            err_flag <= 1'b1;
         end
         if (s_tlast && !is_final) begin
            err_flag <= 1'b1;
         end
      end
   end

   assign err = err_flag;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_deserializer.sv
// Directed bench for axis_deserializer at default parameters (SW=128), plus a
// randomised valid/ready phase checked against a scoreboard of expected beats.
module tb_axis_deserializer;
   import axis_serdes_pkg::*;

   localparam int TDW = 512;
   localparam int TDE = 4;
   localparam int SF  = 4;
   localparam int SW  = TDW / SF;
`ifdef AXIS_DESER_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           s_tvalid;
   logic           s_tready;
   logic [SW-1:0]  s_tdata;
   logic           s_tlast;
   logic [TDE-1:0] s_tdest;
   logic           m_tvalid;
   logic           m_tready;
   logic [TDW-1:0] m_tdata;
   logic           m_tlast;
   logic [TDE-1:0] m_tdest;
   logic           err;

   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int beats_pushed = 0;
   int model_cnt = 0;
   logic [TDW-1:0] model_acc = '0;
   axis_beat_t exp_q[$];
   logic rnd_on = 1'b0;

   axis_deserializer #(
      .TDATA_WIDTH          (TDW),
      .TDEST_WIDTH          (TDE),
      .SERIALIZATION_FACTOR (SF)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tdata  (s_tdata),
      .s_tlast  (s_tlast),
      .s_tdest  (s_tdest),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tdata  (m_tdata),
      .m_tlast  (m_tlast),
      .m_tdest  (m_tdest),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TDW-1:0] obs, input logic [TDW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [TDW-1:0] d, input logic last, input logic [TDE-1:0] dest);
      axis_beat_t b;
      b.tdata = d;
      b.tlast = last;
      b.tdest = dest;
      exp_q.push_back(b);
      beats_pushed++;
   endtask

   // Present one slice and hold it until accepted; leaves s_tvalid asserted
   task automatic send(input logic [SW-1:0] d, input logic last, input logic [TDE-1:0] dest,
                       output int waited);
      logic rdy;
      logic accepted;
      accepted = 1'b0;
      waited   = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      s_tdest  = dest;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         rdy = s_tready;
         @(posedge clk);
         #1;
         if (rdy) begin
            accepted = 1'b1;
            break;
         end
         waited++;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed not-accepted expected accepted");
      end else begin
         model_acc[model_cnt*SW +: SW] = d;
         if (model_cnt == SF - 1) begin
            push_exp(model_acc, last, dest);
            model_cnt = 0;
         end else begin
            model_cnt++;
         end
      end
   endtask

   // Scoreboard: every output handshake must match the oldest expected beat
   always @(posedge clk) begin
      if (rst_n && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_extra observed beat %h expected none", m_tdata);
         end else begin
            axis_beat_t e;
            e = exp_q.pop_front();
            chk("sb_data", m_tdata, e.tdata);
            chk("sb_last", {511'd0, m_tlast}, {511'd0, e.tlast});
            chk("sb_dest", {508'd0, m_tdest}, {508'd0, e.tdest});
            beats_seen++;
         end
      end
   end

   // Random downstream ready while the random phase is active
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_on) m_tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [TDW-1:0] b1;
      logic [TDW-1:0] b2;
      logic [TDE-1:0] rdest;

      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      s_tdest  = '0;
      m_tready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", {511'd0, m_tvalid}, '0);
      chk("rst_m_tdata", m_tdata, '0);
      chk("rst_m_tlast", {511'd0, m_tlast}, '0);
      chk("rst_m_tdest", {508'd0, m_tdest}, '0);
      chk("rst_err", {511'd0, err}, '0);
      chk("rst_s_tready", {511'd0, s_tready}, 512'd1);
      step();
      rst_n = 1'b1;
      chk("post_rst_s_tready", {511'd0, s_tready}, 512'd1);

      // Single beat A,B,C,D
      m_tready = 1'b1;
      send(128'hA, 1'b0, 4'h3, w);
      send(128'hB, 1'b0, 4'h3, w);
      send(128'hC, 1'b0, 4'h3, w);
      chk("t1_not_yet_valid", {511'd0, m_tvalid}, '0);
      send(128'hD, 1'b1, 4'h3, w);
      s_tvalid = 1'b0;
      chk("t1_valid", {511'd0, m_tvalid}, 512'd1);
      chk("t1_data", m_tdata, {128'hD, 128'hC, 128'hB, 128'hA});
      chk("t1_dest", {508'd0, m_tdest}, 512'd3);
      chk("t1_last", {511'd0, m_tlast}, 512'd1);
      $display("beat single data=%h dest=%0d last=%0d", m_tdata[15:0], m_tdest, m_tlast);
      step();
      chk("t1_drained", {511'd0, m_tvalid}, '0);

      // Two beats back to back with downstream always ready
      for (int i = 0; i < 8; i++) begin
         send(128'h100 + 128'(i), (i == 3) || (i == 7), 4'h5, w);
         chk("b2b_no_wait", 512'(w), '0);
         if (i == 3) chk("b2b_beat1", m_tdata, {128'h103, 128'h102, 128'h101, 128'h100});
         if (i == 4) chk("b2b_drained", {511'd0, m_tvalid}, '0);
      end
      s_tvalid = 1'b0;
      chk("b2b_valid2", {511'd0, m_tvalid}, 512'd1);
      chk("b2b_beat2", m_tdata, {128'h107, 128'h106, 128'h105, 128'h104});
      $display("beat b2b data=%h dest=%0d", m_tdata[15:0], m_tdest);
      step();

      // Backpressure: beat 1 held, beat 2 final slice stalls
      m_tready = 1'b0;
      b1 = {128'h44, 128'h33, 128'h22, 128'h11};
      b2 = {128'h88, 128'h77, 128'h66, 128'h55};
      send(128'h11, 1'b0, 4'h6, w);
      send(128'h22, 1'b0, 4'h6, w);
      send(128'h33, 1'b0, 4'h6, w);
      send(128'h44, 1'b1, 4'h6, w);
      chk("bp_b1_valid", {511'd0, m_tvalid}, 512'd1);
      chk("bp_b1_data", m_tdata, b1);
      send(128'h55, 1'b0, 4'h7, w);
      chk("bp_s0_no_wait", 512'(w), '0);
      send(128'h66, 1'b0, 4'h7, w);
      chk("bp_s1_no_wait", 512'(w), '0);
      send(128'h77, 1'b0, 4'h7, w);
      chk("bp_s2_no_wait", 512'(w), '0);
      s_tdata  = 128'h88;
      s_tlast  = 1'b1;
      s_tdest  = 4'h7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_stall_ready", {511'd0, s_tready}, '0);
         chk("bp_stall_data", m_tdata, b1);
         chk("bp_stall_dest", {508'd0, m_tdest}, 512'd6);
      end
      m_tready = 1'b1;
      #1;
      chk("bp_release_ready", {511'd0, s_tready}, 512'd1);
      step();
      s_tvalid  = 1'b0;
      model_cnt = 0;
      push_exp(b2, 1'b1, 4'h7);
      chk("bp_reload_valid", {511'd0, m_tvalid}, 512'd1);
      chk("bp_b2_data", m_tdata, b2);
      chk("bp_b2_dest", {508'd0, m_tdest}, 512'd7);
      $display("beat backpressure data=%h dest=%0d", m_tdata[15:0], m_tdest);
      step();
      chk("bp_drained", {511'd0, m_tvalid}, '0);

      // Reset in the middle of a beat
      send(128'hDEAD0, 1'b0, 4'h2, w);
      send(128'hDEAD1, 1'b0, 4'h2, w);
      s_tvalid = 1'b0;
      @(negedge clk);
      rst_n     = 1'b0;
      model_cnt = 0;
      #1;
      chk("mid_rst_ready", {511'd0, s_tready}, 512'd1);
      chk("mid_rst_valid", {511'd0, m_tvalid}, '0);
      step();
      rst_n = 1'b1;
      send(128'hE, 1'b0, 4'h9, w);
      send(128'hF, 1'b0, 4'h9, w);
      send(128'h10, 1'b0, 4'h9, w);
      send(128'h11, 1'b1, 4'h9, w);
      s_tvalid = 1'b0;
      chk("rst_beat_data", m_tdata, {128'h11, 128'h10, 128'hF, 128'hE});
      chk("rst_beat_dest", {508'd0, m_tdest}, 512'd9);
      $display("beat after-reset data=%h dest=%0d", m_tdata[15:0], m_tdest);
      step();

      // tdest changes mid-beat
      send(128'h1, 1'b0, 4'h1, w);
      send(128'h2, 1'b0, 4'h1, w);
      send(128'h3, 1'b0, 4'h2, w);
      send(128'h4, 1'b1, 4'h1, w);
      s_tvalid = 1'b0;
      chk("err_beat_data", m_tdata, {128'h4, 128'h3, 128'h2, 128'h1});
      chk("err_beat_dest", {508'd0, m_tdest}, 512'd1);
      chk("err_flag", {511'd0, err}, {511'd0, ERR_EXP});
      $display("beat dest-mismatch dest=%0d err=%0d", m_tdest, err);
      step();
      for (int i = 0; i < 4; i++) send(128'h20 + 128'(i), i == 3, 4'h4, w);
      s_tvalid = 1'b0;
      step();
      chk("err_sticky", {511'd0, err}, {511'd0, ERR_EXP});

      // Random valid/ready over 1000 beats
      rnd_on = 1'b1;
      for (int b = 0; b < 1000; b++) begin
         rdest = 4'($urandom_range(0, 15));
         for (int k = 0; k < SF; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               s_tvalid = 1'b0;
               step();
            end
            send({$urandom(), $urandom(), $urandom(), $urandom()},
                 (k == SF - 1) ? 1'($urandom_range(0, 1)) : 1'b0, rdest, w);
         end
         if (b % 100 == 99) $display("random beats sent=%0d seen=%0d", b + 1, beats_seen);
      end
      s_tvalid = 1'b0;
      rnd_on   = 1'b0;
      step();
      m_tready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      chk("rnd_queue_empty", 512'(exp_q.size()), '0);
      chk("rnd_beat_count", 512'(beats_seen), 512'(beats_pushed));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
